ptn_seq_ctrl: RTL and testbench
===============================

// Module: ptn_seq_ctrl
// PURPOSE
//  Frame-synchronous sequencer for the pattern generator: drives its pattern-type select so that test
//  patterns change only at frame boundaries. Auto mode cycles patterns every HOLD_FRAMES frames; manual
//  mode applies a requested type at the next frame. Watches the generator's VSync/DE outputs.
// PARAMETERS
//  NUM_PTN      2   number of patterns; legal types 0..NUM_PTN-1 (NUM_PTN >= 2, <= 2**TYPE_W)
//  TYPE_W       1   width of pattern-type select
//  HOLD_FRAMES  60  frames each pattern is held in auto mode (>= 1)
//  CNT_W        16  frame counter width
//  INIT_TYPE    0   pattern type driven out of reset (must be < NUM_PTN)
//  VS_POL       1   active level of i_VSync
// PORTS
//  i_clk          in   1       pixel clock
//  i_rst          in   1       synchronous reset, active-low
//  i_en           in   1       1 = sequencer running; 0 = go IDLE, hold outputs
//  i_mode         in   1       0 = auto cycle, 1 = manual
//  i_manual_type  in   TYPE_W  type to apply on manual step
//  i_step         in   1       1-cycle pulse: request manual switch at next frame boundary
//  i_VSync        in   1       VSync from pattern generator
//  i_DE           in   1       DE from pattern generator
//  o_PTN_type     out  TYPE_W  pattern select to generator
//  o_switch       out  1       1-cycle pulse, high in the cycle o_PTN_type takes a new value
//  o_frame_cnt    out  CNT_W   frames since last switch (or since alignment)
//  o_err          out  1       sticky: boundary seen with DE high, or out-of-range manual type
//  o_state        out  2       0 IDLE, 1 WAIT_VS, 2 RUN
// BEHAVIOUR
//  Reset (i_rst==0 at posedge): o_PTN_type=INIT_TYPE, o_switch=0, o_frame_cnt=0, o_err=0, state IDLE,
//   step_pend=0, vs_d=VS_POL (suppresses false edge if VSync already active at reset release).
//  vs_d <= i_VSync every cycle. vs_edge = (i_VSync==VS_POL) && (vs_d!=VS_POL), combinational.
//  All outputs registered; a switch decided on a vs_edge cycle is visible the next cycle (latency 1).
//  FSM:
//   IDLE: i_en=1 -> WAIT_VS. Outputs hold.
//   WAIT_VS: vs_edge -> RUN, o_frame_cnt<=0 (alignment to first full frame; no switch).
//   RUN: on each vs_edge (boundary):
//    - if i_DE==1: boundary is illegal; o_err<=1, no switch, counter unchanged, pending kept.
//    - else o_frame_cnt <= o_frame_cnt+1 (saturating at 2**CNT_W-1), then mode rules (i_mode sampled here):
//    - auto: if o_frame_cnt >= HOLD_FRAMES-1: o_PTN_type <= (type==NUM_PTN-1) ? 0 : type+1,
//      o_frame_cnt<=0, o_switch<=1.
//    - manual: if step_pend|i_step: if i_manual_type<NUM_PTN: o_PTN_type<=i_manual_type, o_frame_cnt<=0,
//      o_switch<=1 (even if same value); else o_err<=1, type held. step_pend<=0 either way.
//  step_pend: set by i_step in RUN/WAIT_VS when not consumed same cycle; multiple steps merge into one;
//   i_manual_type is sampled at the boundary, not at the step. i_step ignored in IDLE and in auto mode
//   (pending cleared when boundary seen in auto mode).
//  i_en=0 in any state: next state IDLE, step_pend<=0, o_switch<=0; o_PTN_type/o_frame_cnt hold.
//   Re-enable always re-aligns via WAIT_VS.
//  Mode change mid-run: effective at next boundary; counter not reset (>= compare avoids miss).
//  o_switch is 0 in every cycle not following a switching boundary. o_err clears only on reset.
//  Reset mid-frame: all state to reset values in that cycle; generator type returns to INIT_TYPE.
// TESTING
//  1 Reset: i_rst=0 for 2 clk with i_VSync=1 -> type=INIT_TYPE, cnt=0, err=0, state=0; release, no edge.
//  2 Auto, HOLD_FRAMES=2, NUM_PTN=2, en=1: 6 VSync pulses (DE=0) -> 1st aligns (state=2), switches
//    0->1 after 3rd, 1->0 after 5th; o_switch one cycle each, 1 clk after VSync rise.
//  3 Manual: i_step pulse mid-frame, i_manual_type changed 0->1 before next VSync -> type=1 after that
//    VSync, cnt=0; second step with type=2 (NUM_PTN=2) -> no switch, o_err=1.
//  4 Illegal boundary: VSync rise while i_DE=1 -> no count, no switch, o_err=1 and sticky.
//  5 i_en=0 mid-frame -> state=0 next clk, type holds; en=1 -> WAIT_VS, first VSync only re-aligns.
//  6 i_step coincident with VSync rise in manual -> switch on that boundary; step then pend is one switch.

Source files
------------

// File: rtl/ptn_seq_ctrl.sv
// Frame-synchronous pattern-type sequencer: changes the generator's pattern select only on VSync
// leading edges, cycling automatically every HOLD_FRAMES frames or applying a requested manual type.
module ptn_seq_ctrl #(
  parameter int unsigned NUM_PTN     = 2,
  parameter int unsigned TYPE_W      = 1,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned INIT_TYPE   = 0,
  parameter logic        VS_POL      = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [TYPE_W-1:0] i_manual_type,
  input  logic              i_step,
  input  logic              i_VSync,
  input  logic              i_DE,
  output logic [TYPE_W-1:0] o_PTN_type,
  output logic              o_switch,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic              o_err,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [TYPE_W-1:0] INIT_TYPE_L = TYPE_W'(INIT_TYPE);
  localparam logic [TYPE_W-1:0] LAST_TYPE_L = TYPE_W'(NUM_PTN - 1);
  localparam logic [TYPE_W:0]   NUM_PTN_L   = (TYPE_W + 1)'(NUM_PTN);
  localparam logic [CNT_W-1:0]  HOLD_M1_L   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO_L  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX_L   = {CNT_W{1'b1}};

  state_t              state_r;
  logic [TYPE_W-1:0]   ptn_type_r;
  logic                switch_r;
  logic [CNT_W-1:0]    frame_cnt_r;
  logic                err_r;
  logic                step_pend_r;
  logic                vs_d_r;

  logic                vs_edge_s;
  logic                step_new_s;
  logic                step_req_s;
  logic                type_ok_s;
  logic                hold_done_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [TYPE_W-1:0]   type_next_s;

  assign vs_edge_s   = (i_VSync == VS_POL) && (vs_d_r != VS_POL);
  // Steps only count in manual mode; a pending step plus a fresh one still make one request.
  assign step_new_s  = i_step & i_mode;
  assign step_req_s  = step_pend_r | i_step;
  assign type_ok_s   = ({1'b0, i_manual_type} < NUM_PTN_L);
  assign hold_done_s = (frame_cnt_r >= HOLD_M1_L);
  assign cnt_inc_s   = (frame_cnt_r == CNT_MAX_L) ? frame_cnt_r : frame_cnt_r + CNT_W'(1);
  assign type_next_s = (ptn_type_r == LAST_TYPE_L) ? {TYPE_W{1'b0}} : ptn_type_r + TYPE_W'(1);

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r     <= ST_IDLE;
      ptn_type_r  <= INIT_TYPE_L;
      switch_r    <= 1'b0;
      frame_cnt_r <= CNT_ZERO_L;
      err_r       <= 1'b0;
      step_pend_r <= 1'b0;
      vs_d_r      <= VS_POL;
    end else begin
      vs_d_r   <= i_VSync;
      switch_r <= 1'b0;
      if (!i_en) begin
        state_r     <= ST_IDLE;
        step_pend_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_WAIT_VS;
          end
          ST_WAIT_VS: begin
            step_pend_r <= step_pend_r | step_new_s;
            if (vs_edge_s) begin
              state_r     <= ST_RUN;
              frame_cnt_r <= CNT_ZERO_L;
            end
          end
          ST_RUN: begin
            if (!vs_edge_s) begin
              step_pend_r <= step_pend_r | step_new_s;
            end else if (i_DE) begin
              // Boundary during active video: flag it and leave everything else alone.
              err_r       <= 1'b1;
              step_pend_r <= step_pend_r | step_new_s;
            end else begin
              step_pend_r <= 1'b0;
              if (!i_mode) begin
                if (hold_done_s) begin
                  ptn_type_r  <= type_next_s;
                  frame_cnt_r <= CNT_ZERO_L;
                  switch_r    <= 1'b1;
                end else begin
                  frame_cnt_r <= cnt_inc_s;
                end
              end else if (step_req_s && type_ok_s) begin
                ptn_type_r  <= i_manual_type;
                frame_cnt_r <= CNT_ZERO_L;
                switch_r    <= 1'b1;
              end else begin
                frame_cnt_r <= cnt_inc_s;
                if (step_req_s) begin
                  err_r <= 1'b1;
                end else begin
                  err_r <= err_r;
                end
              end
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            step_pend_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_PTN_type  = ptn_type_r;
  assign o_switch    = switch_r;
  assign o_frame_cnt = frame_cnt_r;
  assign o_err       = err_r;
  assign o_state     = state_r;

endmodule

// File: tb/tb_ptn_seq_ctrl.sv
// Directed-vector bench for ptn_seq_ctrl: table of per-cycle inputs and hand-computed outputs,
// followed by hand-written sequences for coincident/merged steps and mid-frame reset.
module tb_ptn_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, mode, step, vs, de;
  logic [1:0]  mtype;
  logic [1:0]  ptn_type;
  logic        sw;
  logic [15:0] frame_cnt;
  logic        err;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ptn_seq_ctrl #(
    .NUM_PTN(2), .TYPE_W(2), .HOLD_FRAMES(2), .CNT_W(16), .INIT_TYPE(0), .VS_POL(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_manual_type(mtype),
    .i_step(step), .i_VSync(vs), .i_DE(de),
    .o_PTN_type(ptn_type), .o_switch(sw), .o_frame_cnt(frame_cnt), .o_err(err), .o_state(state)
  );

  typedef struct {
    string name;
    logic rst, en, mode;
    logic [1:0] mt;
    logic step, vs, de;
    logic [1:0] e_type;
    logic e_sw;
    logic [15:0] e_cnt;
    logic e_err;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, int r, int e, int m, int mt, int s, int v, int d,
                              int et, int esw, int ec, int eer, int est);
    vec_t x;
    x.name = nm; x.rst = r[0]; x.en = e[0]; x.mode = m[0]; x.mt = mt[1:0];
    x.step = s[0]; x.vs = v[0]; x.de = d[0];
    x.e_type = et[1:0]; x.e_sw = esw[0]; x.e_cnt = ec[15:0]; x.e_err = eer[0]; x.e_st = est[1:0];
    return x;
  endfunction

  task automatic chk(string nm, int idx, string fld, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] %s: got %0d expected %0d", nm, idx, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare registered outputs 1ns after the clock edge.
  task automatic apply(vec_t v, int idx);
    rst = v.rst; en = v.en; mode = v.mode; mtype = v.mt; step = v.step; vs = v.vs; de = v.de;
    @(posedge clk);
    #1;
    chk(v.name, idx, "type",  int'(ptn_type),  int'(v.e_type));
    chk(v.name, idx, "sw",    int'(sw),        int'(v.e_sw));
    chk(v.name, idx, "cnt",   int'(frame_cnt), int'(v.e_cnt));
    chk(v.name, idx, "err",   int'(err),       int'(v.e_err));
    chk(v.name, idx, "state", int'(state),     int'(v.e_st));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; mtype = 2'd0; step = 1'b0; vs = 1'b1; de = 1'b0;
    //                  name       rst en md mt st vs de   type sw cnt err st
    vecs.push_back(mk("reset",      0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk("reset",      0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk("release",    1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1));
    vecs.push_back(mk("no_edge",    1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1));
    vecs.push_back(mk("vs_low",     1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
    // auto mode, HOLD_FRAMES=2
    vecs.push_back(mk("auto_align", 1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mk("auto",       1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mk("auto_vs2",   1, 1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2));
    vecs.push_back(mk("auto",       1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2));
    vecs.push_back(mk("auto_vs3",   1, 1, 0, 0, 0, 1, 0,   1, 1, 0, 0, 2));
    vecs.push_back(mk("auto_swoff", 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2));
    vecs.push_back(mk("auto_vs4",   1, 1, 0, 0, 0, 1, 0,   1, 0, 1, 0, 2));
    vecs.push_back(mk("auto",       1, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 2));
    vecs.push_back(mk("auto_vs5",   1, 1, 0, 0, 0, 1, 0,   0, 1, 0, 0, 2));
    vecs.push_back(mk("auto_swoff", 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mk("auto_vs6",   1, 1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2));
    vecs.push_back(mk("auto",       1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2));
    // illegal boundary with DE high, then sticky err across a legal switch
    vecs.push_back(mk("de_bound",   1, 1, 0, 0, 0, 1, 1,   0, 0, 1, 1, 2));
    vecs.push_back(mk("de_sticky",  1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 2));
    vecs.push_back(mk("de_after",   1, 1, 0, 0, 0, 1, 0,   1, 1, 0, 1, 2));
    vecs.push_back(mk("de_after",   1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 2));
    vecs.push_back(mk("rst_type",   0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk("rst_rel",    1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
    vecs.push_back(mk("realign",    1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mk("realign",    1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2));
    // manual: step mid-frame, type sampled at boundary; then out-of-range type
    vecs.push_back(mk("man_step",   1, 1, 1, 0, 1, 0, 1,   0, 0, 0, 0, 2));
    vecs.push_back(mk("man_chg",    1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mk("man_vs",     1, 1, 1, 1, 0, 1, 0,   1, 1, 0, 0, 2));
    vecs.push_back(mk("man_swoff",  1, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 2));
    vecs.push_back(mk("man_bad",    1, 1, 1, 2, 1, 0, 0,   1, 0, 0, 0, 2));
    vecs.push_back(mk("man_bad_vs", 1, 1, 1, 2, 0, 1, 0,   1, 0, 1, 1, 2));
    vecs.push_back(mk("man_bad",    1, 1, 1, 2, 0, 0, 0,   1, 0, 1, 1, 2));
    // disable mid-frame with a step: pending discarded, re-enable re-aligns only
    vecs.push_back(mk("dis",        1, 0, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0));
    vecs.push_back(mk("dis_vs",     1, 0, 1, 0, 0, 1, 0,   1, 0, 1, 1, 0));
    vecs.push_back(mk("reen",       1, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1));
    vecs.push_back(mk("reen_vs",    1, 1, 1, 0, 0, 1, 0,   1, 0, 0, 1, 2));
    vecs.push_back(mk("reen",       1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 1, 2));
    vecs.push_back(mk("no_pend",    1, 1, 1, 0, 0, 1, 0,   1, 0, 1, 1, 2));
    vecs.push_back(mk("no_pend",    1, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 2));

    foreach (vecs[i]) apply(vecs[i], i);

    // step coincident with VSync rise switches on that boundary
    apply(mk("coinc_vs",   1, 1, 1, 0, 1, 1, 0,   0, 1, 0, 1, 2), 100);
    apply(mk("coinc",      1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 2), 101);
    // two steps merge into one pending request, giving exactly one switch
    apply(mk("merge1",     1, 1, 1, 0, 1, 0, 0,   0, 0, 0, 1, 2), 102);
    apply(mk("merge2",     1, 1, 1, 0, 1, 0, 0,   0, 0, 0, 1, 2), 103);
    apply(mk("merge_vs",   1, 1, 1, 1, 0, 1, 0,   1, 1, 0, 1, 2), 104);
    apply(mk("merge",      1, 1, 1, 1, 0, 0, 0,   1, 0, 0, 1, 2), 105);
    apply(mk("merge_once", 1, 1, 1, 1, 0, 1, 0,   1, 0, 1, 1, 2), 106);
    apply(mk("merge",      1, 1, 1, 1, 0, 0, 0,   1, 0, 1, 1, 2), 107);
    // step in auto mode is ignored even if mode flips before the boundary
    apply(mk("auto_step",  1, 1, 0, 0, 1, 0, 0,   1, 0, 1, 1, 2), 108);
    apply(mk("auto_st_vs", 1, 1, 1, 0, 0, 1, 0,   1, 0, 2, 1, 2), 109);
    apply(mk("auto_step",  1, 1, 1, 0, 0, 0, 0,   1, 0, 2, 1, 2), 110);
    // reset mid-frame returns everything to reset values
    apply(mk("mid_rst",    0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0), 111);
    apply(mk("mid_rel",    1, 1, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1), 112);
    apply(mk("mid_wait",   1, 1, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1), 113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
